// File: rtl/nwcc_multich_gated_pkg.sv
// Shared types and helpers for the multichannel shift-register coincidence counter.
package nwcc_multich_gated_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of a per-tick event count (0..n_ch).
  function automatic int cnt_width(input int n_ch);
    return $clog2(n_ch + 1);
  endfunction

  // Width of a gate accumulator (0..gate*n_ch).
  function automatic int acc_width(input int gate, input int n_ch);
    return $clog2(gate * n_ch + 1);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/nwcc_multich_gated_if.sv
// Pulse/control/result bundle between the coincidence counter and its environment.
interface nwcc_multich_gated_if #(
  parameter int N_CH      = 4,
  parameter int DATA_BITS = 24
);
  logic [N_CH-1:0]      i_pulse;
  logic                 i_start;
  logic                 i_stop;
  logic                 o_busy;
  logic                 o_done;
  logic [DATA_BITS-1:0] o_total_count;
  logic [DATA_BITS-1:0] o_r_plus_a_count;
  logic [DATA_BITS-1:0] o_a_count;
  logic [31:0]          o_elapsed;
  logic                 o_overflow;

  modport master (
    output i_pulse, i_start, i_stop,
    input  o_busy, o_done, o_total_count, o_r_plus_a_count, o_a_count, o_elapsed, o_overflow
  );

  modport slave (
    input  i_pulse, i_start, i_stop,
    output o_busy, o_done, o_total_count, o_r_plus_a_count, o_a_count, o_elapsed, o_overflow
  );
endinterface

// File: rtl/nwcc_multich_gated_delay_line.sv
// Circular-buffer delay line with two taps: TAP_A ticks and DEPTH ticks behind the input.
module nwcc_delay_line #(
  parameter int DEPTH = 8,
  parameter int TAP_A = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] tap_a_o,
  output logic [W-1:0] tap_b_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rd_a;

  always_comb begin
    wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    // Slot written d ticks ago sits d positions behind the write pointer.
    if (wptr_q >= PTR_W'(TAP_A)) rd_a = wptr_q - PTR_W'(TAP_A);
    else                         rd_a = wptr_q + PTR_W'(DEPTH - TAP_A);
  end

  assign tap_a_o = mem_q[rd_a];
  assign tap_b_o = mem_q[wptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q[wptr_q] <= din_i;
      wptr_q        <= wptr_d;
    end
  end
endmodule

// File: rtl/nwcc_multich_gated.sv
// Multichannel shift-register coincidence counter (R+A / A gates) with measurement FSM.
// Optional macro NWCC_SAT_EN: result counters saturate and o_overflow is sticky; otherwise they wrap.
module nwcc_multich_gated
  import nwcc_multich_gated_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int PREDELAY   = 8,
  parameter int GATE       = 128,
  parameter int LONG_DLY   = 1024,
  parameter int COUNT_TIME = 1000000,
  parameter int DATA_BITS  = 24
) (
  input  logic i_clk_1mhz,
  input  logic i_reset,
  nwcc_multich_gated_if.slave bus
);
  localparam int CW = cnt_width(N_CH);
  localparam int AW = acc_width(GATE, N_CH);
  localparam int PW = CW + AW;

  state_e               state_q, state_d;
  logic [31:0]          elapsed_q, elapsed_d;
  logic [N_CH-1:0]      pulse_q;
  logic [N_CH-1:0]      events;
  logic [CW-1:0]        n_ev, tap_p, tap_pg, tap_l, tap_lg;
  logic [AW-1:0]        acc_ra_q, acc_ra_d, acc_a_q, acc_a_d;
  logic [PW-1:0]        prod_ra, prod_a;
  logic [DATA_BITS-1:0] total_q, total_d, ra_q, ra_d, a_q, a_d;
  logic [DATA_BITS-1:0] t_next, ra_next, a_next;
  logic                 run, done;

  assign events = bus.i_pulse & ~pulse_q;
  assign n_ev   = CW'(popcount16(16'(events)));

  nwcc_delay_line #(.DEPTH(PREDELAY + GATE), .TAP_A(PREDELAY), .W(CW)) u_dl_ra (
    .clk(i_clk_1mhz), .rst(i_reset), .din_i(n_ev), .tap_a_o(tap_p), .tap_b_o(tap_pg)
  );

  nwcc_delay_line #(.DEPTH(LONG_DLY + GATE), .TAP_A(LONG_DLY), .W(CW)) u_dl_a (
    .clk(i_clk_1mhz), .rst(i_reset), .din_i(n_ev), .tap_a_o(tap_l), .tap_b_o(tap_lg)
  );

  // Sliding gate sums: add the event entering the gate, drop the one leaving it.
  assign acc_ra_d = acc_ra_q + AW'(tap_p) - AW'(tap_pg);
  assign acc_a_d  = acc_a_q + AW'(tap_l) - AW'(tap_lg);

  assign prod_ra = PW'(n_ev) * PW'(acc_ra_q);
  assign prod_a  = PW'(n_ev) * PW'(acc_a_q);

`ifdef NWCC_SAT_EN
  localparam int EW = ((DATA_BITS > PW) ? DATA_BITS : PW) + 1;

  logic ovf_q, ovf_d, ovf_t, ovf_ra, ovf_a;

  function automatic logic [DATA_BITS:0] acc_add(input logic [DATA_BITS-1:0] cnt,
                                                input logic [PW-1:0]        inc);
    logic [EW-1:0] sum;
    sum = EW'(cnt) + EW'(inc);
    if (sum > EW'({DATA_BITS{1'b1}})) return {1'b1, {DATA_BITS{1'b1}}};
    return {1'b0, sum[DATA_BITS-1:0]};
  endfunction

  assign {ovf_t, t_next}   = acc_add(total_q, PW'(n_ev));
  assign {ovf_ra, ra_next} = acc_add(ra_q, prod_ra);
  assign {ovf_a, a_next}   = acc_add(a_q, prod_a);

  always_comb begin
    ovf_d = ovf_q;
    if (run)              ovf_d = ovf_q | ovf_t | ovf_ra | ovf_a;
    else if (bus.i_start) ovf_d = 1'b0;
  end

  always_ff @(posedge i_clk_1mhz or posedge i_reset) begin
    if (i_reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign bus.o_overflow = ovf_q;
`else
  function automatic logic [DATA_BITS-1:0] acc_add(input logic [DATA_BITS-1:0] cnt,
                                                  input logic [PW-1:0]        inc);
    return cnt + DATA_BITS'(inc);
  endfunction

  assign t_next  = acc_add(total_q, PW'(n_ev));
  assign ra_next = acc_add(ra_q, prod_ra);
  assign a_next  = acc_add(a_q, prod_a);

  assign bus.o_overflow = 1'b0;
`endif

  assign run = (state_q == ST_RUN);

  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    done      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_start) begin
          state_d   = ST_RUN;
          elapsed_d = '0;
        end
      end
      ST_RUN: begin
        elapsed_d = elapsed_q + 32'd1;
        if (elapsed_q == 32'(COUNT_TIME - 1) || bus.i_stop) begin
          state_d = ST_DONE;
          done    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The tick on which RUN is left is still scored.
  always_comb begin
    total_d = total_q;
    ra_d    = ra_q;
    a_d     = a_q;
    if (run) begin
      total_d = t_next;
      ra_d    = ra_next;
      a_d     = a_next;
    end else if (bus.i_start) begin
      total_d = '0;
      ra_d    = '0;
      a_d     = '0;
    end
  end

  always_ff @(posedge i_clk_1mhz or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      elapsed_q <= '0;
      pulse_q   <= '0;
      acc_ra_q  <= '0;
      acc_a_q   <= '0;
      total_q   <= '0;
      ra_q      <= '0;
      a_q       <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      pulse_q   <= bus.i_pulse;
      acc_ra_q  <= acc_ra_d;
      acc_a_q   <= acc_a_d;
      total_q   <= total_d;
      ra_q      <= ra_d;
      a_q       <= a_d;
    end
  end

  assign bus.o_busy           = run;
  assign bus.o_done           = done;
  assign bus.o_total_count    = total_q;
  assign bus.o_r_plus_a_count = ra_q;
  assign bus.o_a_count        = a_q;
  assign bus.o_elapsed        = elapsed_q;
endmodule

// File: tb/tb_nwcc_multich_gated.sv
// Self-checking bench: gate-sum reference model over an event history, plus directed literal cases.
module tb_nwcc_multich_gated;
  localparam int N_CH = 2;
  localparam int P    = 2;
  localparam int G    = 4;
  localparam int L    = 16;
  localparam int CT   = 100;
  localparam int DB   = 4;
  localparam int MAXV = (1 << DB) - 1;

  logic clk = 1'b0;
  logic rst;
  bit   chk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  nwcc_multich_gated_if #(.N_CH(N_CH), .DATA_BITS(DB)) bus ();

  nwcc_multich_gated #(
    .N_CH(N_CH), .PREDELAY(P), .GATE(G), .LONG_DLY(L), .COUNT_TIME(CT), .DATA_BITS(DB)
  ) dut (
    .i_clk_1mhz(clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int              m_mode;  // 0 idle, 1 run, 2 done
  int              m_el, m_T, m_RA, m_A;
  bit              m_ovf;
  int              hist[$];
  logic [N_CH-1:0] m_prev;
  int              mv_ev, mv_ra, mv_a, mv_t;
  bit              mv_end;

  function automatic int madd(input int cur, input int inc);
    int s;
    s = cur + inc;
`ifdef NWCC_SAT_EN
    if (s > MAXV) begin
      m_ovf = 1'b1;
      return MAXV;
    end
    return s;
`else
    return s % (MAXV + 1);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_el = 0; m_T = 0; m_RA = 0; m_A = 0; m_ovf = 1'b0;
      hist.delete();
      m_prev = '0;
    end else begin
      mv_t  = hist.size();
      mv_ev = $countones(bus.i_pulse & ~m_prev);
      m_prev = bus.i_pulse;
      mv_ra = 0;
      mv_a  = 0;
      for (int k = P + 1; k <= P + G; k++) if (mv_t - k >= 0) mv_ra += hist[mv_t - k];
      for (int k = L + 1; k <= L + G; k++) if (mv_t - k >= 0) mv_a += hist[mv_t - k];
      if (m_mode == 1) begin
        mv_end = (m_el == CT - 1) || bus.i_stop;
        m_T  = madd(m_T, mv_ev);
        m_RA = madd(m_RA, mv_ev * mv_ra);
        m_A  = madd(m_A, mv_ev * mv_a);
        m_el++;
        if (mv_end) m_mode = 2;
      end else if (bus.i_start) begin
        m_mode = 1; m_el = 0; m_T = 0; m_RA = 0; m_A = 0; m_ovf = 1'b0;
      end
      hist.push_back(mv_ev);
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("busy",    bus.o_busy, (m_mode == 1));
      chk("done",    bus.o_done, (m_mode == 1) && ((m_el == CT - 1) || bus.i_stop));
      chk("total",   bus.o_total_count, m_T);
      chk("r_plus_a", bus.o_r_plus_a_count, m_RA);
      chk("a_gate",  bus.o_a_count, m_A);
      chk("elapsed", bus.o_elapsed, m_el);
      chk("overflow", bus.o_overflow, m_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [1:0] p, input bit st, input bit sp);
    bus.i_pulse = p;
    bus.i_start = st;
    bus.i_stop  = sp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  bus.o_busy, 0);
    chk({tag, "_done"},  bus.o_done, 0);
    chk({tag, "_total"}, bus.o_total_count, 0);
    chk({tag, "_ra"},    bus.o_r_plus_a_count, 0);
    chk({tag, "_a"},     bus.o_a_count, 0);
    chk({tag, "_el"},    bus.o_elapsed, 0);
    chk({tag, "_ovf"},   bus.o_overflow, 0);
  endtask

  task automatic scenario(input string nm, input int t1, input logic [1:0] m1,
                          input int t2, input logic [1:0] m2, input int w, input int stop_at,
                          input int eT, input int eRA, input int eA, input int eEl, input int eDone);
    int         done_tick;
    logic [1:0] p;
    done_tick = -1;
    step(2'b00, 1'b1, 1'b0);
    for (int t = 0; t < 130 && done_tick < 0; t++) begin
      p = 2'b00;
      if (t >= t1 && t < t1 + w) p = p | m1;
      if (t >= t2 && t < t2 + w) p = p | m2;
      bus.i_pulse = p;
      bus.i_start = 1'b0;
      bus.i_stop  = (t == stop_at);
      #5;
      if (bus.o_done) done_tick = t;
      @(posedge clk);
      #1;
    end
    bus.i_pulse = '0;
    bus.i_stop  = 1'b0;
    chk({nm, "_done_tick"}, done_tick, eDone);
    chk({nm, "_T"},   bus.o_total_count, eT);
    chk({nm, "_RA"},  bus.o_r_plus_a_count, eRA);
    chk({nm, "_A"},   bus.o_a_count, eA);
    chk({nm, "_el"},  bus.o_elapsed, eEl);
    chk({nm, "_busy"}, bus.o_busy, 0);
    chk({nm, "_model_T"},  m_T, eT);
    chk({nm, "_model_RA"}, m_RA, eRA);
    chk({nm, "_model_A"},  m_A, eA);
    step(2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] p;
    bit         st, sp;
    int         expT, expRA, expA, expOvf;
    rst = 1'b1;
    bus.i_pulse = '0;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    #12;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    step(2'b00, 1'b0, 1'b1);  // stop while idle is ignored
    step(2'b00, 1'b0, 1'b0);

    scenario("single",   5, 2'b01, -100, 2'b00, 1, -1, 1, 0, 0, 100, 99);
    scenario("ra_hit",  10, 2'b01,   13, 2'b01, 1, -1, 2, 1, 0, 100, 99);
    scenario("predly",  10, 2'b01,   11, 2'b10, 1, -1, 2, 0, 0, 100, 99);
    scenario("a_hit",   10, 2'b01,   28, 2'b01, 1, -1, 2, 0, 1, 100, 99);
    scenario("a_miss",  10, 2'b01,   31, 2'b01, 1, -1, 2, 0, 0, 100, 99);
    scenario("both_ch", 10, 2'b11,   13, 2'b11, 1, -1, 4, 4, 0, 100, 99);
    scenario("wide",    10, 2'b01, -100, 2'b00, 3, -1, 1, 0, 0, 100, 99);
    scenario("stop",     5, 2'b01, -100, 2'b00, 1, 40, 1, 0, 0, 41, 40);

    // Reset in the middle of a run.
    step(2'b00, 1'b1, 1'b0);
    for (int t = 0; t < 20; t++) step((t == 3 || t == 7) ? 2'b11 : 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    #4;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) step(2'b00, 1'b0, 1'b0);
    chk("midrst_idle_busy", bus.o_busy, 0);

    // Twenty coincident two-channel events.
`ifdef NWCC_SAT_EN
    expT = MAXV; expRA = MAXV; expA = MAXV; expOvf = 1;
`else
    expT = 8; expRA = 12; expA = 4; expOvf = 0;
`endif
    step(2'b00, 1'b1, 1'b0);
    for (int t = 0; t < 100; t++) step((t < 40 && t % 2 == 0) ? 2'b11 : 2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0);
    chk("sat_T",   bus.o_total_count, expT);
    chk("sat_RA",  bus.o_r_plus_a_count, expRA);
    chk("sat_A",   bus.o_a_count, expA);
    chk("sat_ovf", bus.o_overflow, expOvf);
    chk("sat_model_T", m_T, expT);

    // Randomized runs, including stray start/stop pulses and one reset.
    for (int r = 0; r < 6; r++) begin
      step(2'b00, 1'b1, 1'b0);
      for (int c = 0; c < 150; c++) begin
        p[0] = ($urandom_range(0, 3) == 0);
        p[1] = ($urandom_range(0, 3) == 0);
        st   = ($urandom_range(0, 60) == 0);
        sp   = ($urandom_range(0, 90) == 0);
        if (r == 3 && c == 60) begin
          rst = 1'b1;
          step(p, 1'b0, 1'b0);
          rst = 1'b0;
        end else begin
          step(p, st, sp);
        end
      end
    end
    step(2'b00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
